// File: rtl/spi_rx_pkg.sv
// Shared constants and FSM state type for the SPI pixel receiver.
package spi_rx_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned NUM_BYTES_DEFAULT = 72;
    localparam int unsigned CNT_W             = 7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StFull = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall pulses
// derived from the synchronized level.
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q_o    = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave receiver that assembles MSB-first bytes and delivers a
// fixed-size frame to a pixel buffer, holding off further bytes until consumed.
module spi_pixel_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned NUM_BYTES   = NUM_BYTES_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    input  logic              image_consumed,
    output logic [0:BYTE_W-1] spi_in,
    output logic              shift_SPI,
    output logic              write_en,
    output logic              image_ready,
    output logic [CNT_W-1:0]  byte_count,
    output logic              overrun_err
);

    logic sclk_s, sclk_rise, unused_sclk_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk_i (clk), .rst_i (rst), .d_i (sclk),
        .q_o (sclk_s), .rise_o (sclk_rise), .fall_o (unused_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk_i (clk), .rst_i (rst), .d_i (ss_n),
        .q_o (ss_s), .rise_o (ss_rise), .fall_o (ss_fall)
    );

    // Same depth as sclk so the sampled data lines up with the detected edge.
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk), .rst_i (rst), .d_i (mosi),
        .q_o (mosi_s), .rise_o (unused_mosi_rise), .fall_o (unused_mosi_fall)
    );

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [0:BYTE_W-2]   shreg_q, shreg_d;
    logic [0:BYTE_W-1]   spi_in_q, spi_in_d;
    logic                pulse_q, pulse_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        spi_in_d     = spi_in_q;
        pulse_d      = 1'b0;
        byte_count_d = byte_count_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            StIdle: if (ss_fall) state_d = StRecv;
            StRecv: if (ss_rise && byte_count_q < CNT_W'(NUM_BYTES)) state_d = StIdle;
            StFull: ;
            default: state_d = StIdle;
        endcase

        // Deselect discards any partial byte.
        if (ss_s) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            sclk_rise_shift: begin
                shreg_d   = {shreg_q[1:BYTE_W-2], mosi_s};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == StFull) begin
                        overrun_d = 1'b1;
                    end else begin
                        spi_in_d     = {shreg_q, mosi_s};
                        pulse_d      = 1'b1;
                        byte_count_d = byte_count_q + 7'd1;
                        state_d      = (byte_count_q == CNT_W'(NUM_BYTES - 1)) ? StFull : StRecv;
                    end
                end
            end
        end

        if (state_q == StFull && image_consumed) begin
            state_d      = StIdle;
            byte_count_d = '0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= '0;
            spi_in_q     <= '0;
            pulse_q      <= 1'b0;
            byte_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            spi_in_q     <= spi_in_d;
            pulse_q      <= pulse_d;
            byte_count_q <= byte_count_d;
            overrun_q    <= overrun_d;
        end
    end

    assign spi_in      = spi_in_q;
    assign shift_SPI   = pulse_q;
    assign write_en    = pulse_q;
    assign image_ready = (state_q == StFull);
    assign byte_count  = byte_count_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Directed-plus-random bench for spi_pixel_rx against a frame-level reference model.
module tb_spi_pixel_rx;

    localparam int unsigned NB   = 72;
    localparam int          HALF = 80;

    logic       clk = 1'b0;
    logic       rst, sclk, ss_n, mosi, image_consumed;
    logic [0:7] spi_in;
    logic       shift_spi, write_en, image_ready, overrun_err;
    logic [6:0] byte_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         m_count;
    bit         m_full;
    bit         m_overrun;

    spi_pixel_rx #(.NUM_BYTES(NB), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk           (sclk),
        .ss_n           (ss_n),
        .mosi           (mosi),
        .image_consumed (image_consumed),
        .spi_in         (spi_in),
        .shift_SPI      (shift_spi),
        .write_en       (write_en),
        .image_ready    (image_ready),
        .byte_count     (byte_count),
        .overrun_err    (overrun_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record every delivered byte; shift_SPI and write_en must agree.
    always @(negedge clk) begin
        if (!rst && (shift_spi || write_en)) begin
            check("we_eq_shift", 32'(write_en), 32'(shift_spi));
            if (shift_spi) got_q.push_back(spi_in);
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_count   = 0;
        m_full    = 1'b0;
        m_overrun = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = v[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
        if (!m_full) begin
            exp_q.push_back(v);
            m_count++;
            if (m_count == NB) m_full = 1'b1;
        end else begin
            m_overrun = 1'b1;
        end
    endtask

    task automatic sel();
        ss_n = 1'b0;
        #40;
    endtask

    task automatic desel();
        #40;
        ss_n = 1'b1;
        #80;
    endtask

    task automatic consume_pulse();
        @(posedge clk);
        #1 image_consumed = 1'b1;
        @(posedge clk);
        #1 image_consumed = 1'b0;
        if (m_full) begin
            m_count   = 0;
            m_full    = 1'b0;
            m_overrun = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_npulse"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, "_count"}, 32'(byte_count), 32'(m_count));
        check({tag, "_ready"}, 32'(image_ready), 32'(m_full));
        check({tag, "_overrun"}, 32'(overrun_err), 32'(m_overrun));
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; image_consumed = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_spi_in", 32'(spi_in), 32'h00);
        check("rst_shift", 32'(shift_spi), 32'h0);
        check("rst_we", 32'(write_en), 32'h0);
        check_state("rst");

        // Single byte
        sel(); send_byte(8'hA5); desel();
        check("single_spi_in", 32'(spi_in), 32'hA5);
        check_state("single");
        compare_stream("single");

        // Full frame of 0..NB-1, with random deselect gaps between bytes
        do_reset();
        sel();
        for (int b = 0; b < int'(NB); b++) begin
            send_byte(8'(b));
            if ($urandom_range(0, 7) == 0) begin desel(); sel(); end
        end
        desel();
        check("frame_spi_in", 32'(spi_in), 32'(NB - 1));
        check_state("frame");
        compare_stream("frame");

        // Byte arriving while full
        sel(); send_byte(8'hFF); desel();
        check("ovr_spi_in", 32'(spi_in), 32'(NB - 1));
        check_state("ovr");
        compare_stream("ovr");
        consume_pulse();
        check_state("consumed");

        // image_consumed outside FULL must be ignored
        sel();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        consume_pulse();
        desel();
        check_state("ign_consume");
        compare_stream("ign_consume");

        // Partial byte abandoned by deselect
        sel(); send_bits(8'($urandom), 5); desel();
        sel(); send_byte(8'h3C); desel();
        check("partial_spi_in", 32'(spi_in), 32'h3C);
        check_state("partial");
        compare_stream("partial");

        // Random bytes up to a count of 10
        sel();
        while (m_count < 10) send_byte(8'($urandom));
        check_state("rand");
        compare_stream("rand");

        // Reset in the middle of a byte
        send_bits(8'($urandom), 4);
        do_reset();
        #200;
        check_state("mid_rst");
        compare_stream("mid_rst");
        desel();
        sel(); send_byte(8'h01); desel();
        check("post_rst_spi_in", 32'(spi_in), 32'h01);
        check_state("post_rst");
        compare_stream("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_pixel_rx.md
SPI_PIXEL_RX -- requirements
Module: spi_pixel_rx

Interface
REQ-001 Parameter NUM_BYTES, default 72: pixel bytes per image frame.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop depth of input synchronizers.
REQ-003 clk  input  1  system clock; one clock domain, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk.
REQ-006 ss_n  input  1  SPI slave select, active-low, asynchronous.
REQ-007 mosi  input  1  SPI serial data, asynchronous.
REQ-008 image_consumed  input  1  one-cycle pulse from control: pixel buffer contents used, accept next frame.
REQ-009 spi_in  output  8  assembled byte, bit index 0 = MSB, to pixel buffer.
REQ-010 shift_SPI  output  1  one-cycle pulse: pixel buffer shifts in spi_in.
REQ-011 write_en  output  1  asserted identically to shift_SPI.
REQ-012 image_ready  output  1  level: NUM_BYTES bytes delivered, frame complete.
REQ-013 byte_count  output  7  bytes delivered in current frame, 0..NUM_BYTES.
REQ-014 overrun_err  output  1  sticky: byte arrived while frame full.

Function
REQ-015 sclk, ss_n, mosi SHALL each pass through SYNC_STAGES flops; all three share equal delay.
REQ-016 SPI mode 0: mosi sampled on synchronized sclk rising edge, MSB first.
REQ-017 Bits SHALL be shifted only while synchronized ss_n = 0.
REQ-018 3-bit bit counter; wraps 7->0 on the 8th sampled bit.
REQ-019 On the 8th bit, spi_in SHALL load the full byte and shift_SPI/write_en SHALL pulse high for exactly one clk cycle, in the cycle after the 8th edge is detected.
REQ-020 spi_in SHALL hold its value until the next completed byte.
REQ-021 FSM states IDLE, RECV, FULL.
REQ-022 IDLE -> RECV on synchronized ss_n falling edge.
REQ-023 RECV -> FULL when the byte making byte_count = NUM_BYTES is delivered; image_ready = 1 from the same cycle as that byte's pulse.
REQ-024 RECV -> IDLE on ss_n rising edge with byte_count < NUM_BYTES; byte_count retained (a frame may span multiple selects).
REQ-025 ss_n rising mid-byte: partial bits discarded, bit counter cleared, no pulse.
REQ-026 FULL: completed bytes SHALL NOT pulse shift_SPI/write_en; each sets overrun_err.
REQ-027 FULL -> IDLE on image_consumed; byte_count cleared to 0, image_ready cleared, same cycle.
REQ-028 image_consumed outside FULL SHALL be ignored, including in the same cycle as the final byte delivery.
REQ-029 overrun_err cleared only by rst or image_consumed.
REQ-030 Required ratio: clk frequency >= 8x sclk frequency; faster sclk is unsupported.

Reset
REQ-031 rst SHALL force: state IDLE, bit counter 0, byte_count 0, spi_in 8'h00, shift_SPI 0, write_en 0, image_ready 0, overrun_err 0, synchronizer flops to idle levels (sclk 0, ss_n 1, mosi 0).
REQ-032 rst mid-byte or mid-frame SHALL discard all partial data with no output pulse.

Structure
REQ-033 Package spi_rx_pkg SHALL hold the state enum, NUM_BYTES default, and byte width constant 8.
REQ-034 Sub-module sync_edge (SYNC_STAGES synchronizer plus rise/fall detect) SHALL be instantiated for sclk and ss_n; mosi uses the same synchronizer without edge detection.

Verification
REQ-035 Reset: assert rst 2 cycles -> all outputs at reset values; byte_count = 0.
REQ-036 Single byte 8'hA5 under ss_n low -> one pulse on shift_SPI/write_en, spi_in = 8'hA5, byte_count = 1.
REQ-037 Stream bytes 0..71 -> 72 pulses, spi_in = 71 on last, image_ready = 1, byte_count = 72.
REQ-038 In FULL, send 8'hFF -> no pulse, spi_in stays 71, overrun_err = 1; then image_consumed -> IDLE, byte_count 0, overrun_err 0.
REQ-039 Send 5 bits, deassert ss_n, reassert, send 8'h3C -> exactly one pulse, spi_in = 8'h3C.
REQ-040 rst after 4 bits of a byte at byte_count 10 -> no pulse, byte_count 0, next full byte 8'h01 delivered as byte 1.
